// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage feeding a downstream shift register's serial input.
// Words arrive over valid/ready and leave one bit per clock, back-to-back with no gap.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_shreg_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last;
    logic             w_accept;

    // Handshake: a word is taken at a rising edge when load_valid and load_ready
    // are both high; load_ready is only offered while idle or on the last bit.
    assign w_last     = (r_state == SHIFT) && (r_cnt == LAST);
    assign load_ready = clear & ((r_state == IDLE) | w_last);
    assign w_accept   = load_valid & load_ready;

    assign w_shifted  = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shreg[WIDTH-1:1]};

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_shreg_nx = r_shreg;
        w_cnt_nx   = r_cnt;
        if (w_accept) begin
            w_state_nx = SHIFT;
            w_shreg_nx = load_data;
            w_cnt_nx   = '0;
        end else if (r_state == SHIFT) begin
            if (w_last) begin
                w_state_nx = IDLE;
                w_shreg_nx = '0;
                w_cnt_nx   = '0;
            end else begin
                w_shreg_nx = w_shifted;
                w_cnt_nx   = r_cnt + CW'(1);
            end
        end
    end

    // Outputs are registered from the next state so they describe the bit on the wire.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            word_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_shreg      <= w_shreg_nx;
            r_cnt        <= w_cnt_nx;
            serial_valid <= (w_state_nx == SHIFT);
            busy         <= (w_state_nx == SHIFT);
            serial_out   <= (w_state_nx == SHIFT) && out_bit(w_shreg_nx);
            frame_start  <= (w_state_nx == SHIFT) && (w_cnt_nx == '0);
            word_done    <= (w_state_nx == SHIFT) && (w_cnt_nx == LAST);
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: 8-bit LSB-first and 4-bit MSB-first instances,
// with an expected-bit queue per instance and a downstream shift-register model.
module tb_piso_serializer;

    logic       clock;
    logic       clear;
    logic [7:0] load_data;
    logic       load_valid;
    logic       load_ready;
    logic       serial_out;
    logic       serial_valid;
    logic       frame_start;
    logic       word_done;
    logic       busy;

    logic [3:0] load_data2;
    logic       load_valid2;
    logic       load_ready2;
    logic       serial_out2;
    logic       serial_valid2;
    logic       frame_start2;
    logic       word_done2;
    logic       busy2;

    int n_checks = 0;
    int n_errors = 0;

    // each entry: {frame_start, word_done, serial_out}
    logic [2:0] exp_q[$];
    logic [2:0] exp2_q[$];
    logic [7:0] dn_reg;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .clock        (clock),
        .clear        (clear),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .word_done    (word_done),
        .busy         (busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut2 (
        .clock        (clock),
        .clear        (clear),
        .load_data    (load_data2),
        .load_valid   (load_valid2),
        .load_ready   (load_ready2),
        .serial_out   (serial_out2),
        .serial_valid (serial_valid2),
        .frame_start  (frame_start2),
        .word_done    (word_done2),
        .busy         (busy2)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word8(input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 0), (i == 7), d[i]});
    endtask

    task automatic push_word4_msb(input logic [3:0] d);
        for (int i = 0; i < 4; i++)
            exp2_q.push_back({(i == 0), (i == 3), d[3-i]});
    endtask

    // scoreboard: push on handshake, pop and compare on every valid bit
    always @(negedge clock) begin
        if (!clear) begin
            dn_reg = 8'h00;
        end else begin
            if (serial_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_bit8", 32'd1, 32'd0);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    check("bit8", {29'd0, frame_start, word_done, serial_out}, {29'd0, e});
                end
                dn_reg = {serial_out, dn_reg[7:1]};
            end else begin
                check("idle_out8", {31'd0, serial_out}, 32'd0);
            end
            if (serial_valid2) begin
                if (exp2_q.size() == 0) begin
                    check("extra_bit4", 32'd1, 32'd0);
                end else begin
                    logic [2:0] e2;
                    e2 = exp2_q.pop_front();
                    check("bit4", {29'd0, frame_start2, word_done2, serial_out2}, {29'd0, e2});
                end
            end
            if (load_valid && load_ready) push_word8(load_data);
            if (load_valid2 && load_ready2) push_word4_msb(load_data2);
        end
    end

    // driver: present a word and hold it until the handshake completes
    task automatic send_word(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        load_data  = d;
        load_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (load_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        load_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        clear       = 1'b0;
        load_data   = 8'h00;
        load_valid  = 1'b0;
        load_data2  = 4'h0;
        load_valid2 = 1'b0;

        // reset values
        repeat (3) tick();
        check("rst_ready",  {31'd0, load_ready},   32'd0);
        check("rst_valid",  {31'd0, serial_valid}, 32'd0);
        check("rst_out",    {31'd0, serial_out},   32'd0);
        check("rst_frame",  {31'd0, frame_start},  32'd0);
        check("rst_done",   {31'd0, word_done},    32'd0);
        check("rst_busy",   {31'd0, busy},         32'd0);
        check("rst_ready2", {31'd0, load_ready2},  32'd0);
        clear = 1'b1;
        tick();
        check("rel_ready",  {31'd0, load_ready},   32'd1);
        check("rel_valid",  {31'd0, serial_valid}, 32'd0);

        // single word 0xB4
        load_data  = 8'hB4;
        load_valid = 1'b1;
        check("s_ready0", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            check("s_ready", {31'd0, load_ready},   {31'd0, (k >= 8)});
            check("s_valid", {31'd0, serial_valid}, {31'd0, (k <= 8)});
            check("s_busy",  {31'd0, busy},         {31'd0, (k <= 8)});
            if (k == 9) check("s_downstream", {24'd0, dn_reg}, 32'h0000_00B4);
            tick();
        end

        // back-to-back 0xA5 then 0x3C with load_valid held
        load_data  = 8'hA5;
        load_valid = 1'b1;
        check("b_ready0", {31'd0, load_ready}, 32'd1);
        tick();
        load_data = 8'h3C;
        for (int k = 1; k <= 17; k++) begin
            if (k == 9) load_valid = 1'b0;
            check("b_ready", {31'd0, load_ready},   {31'd0, (k == 8) || (k >= 16)});
            check("b_valid", {31'd0, serial_valid}, {31'd0, (k <= 16)});
            tick();
        end

        // held request: valid during cycles 2..7 with changing data is ignored
        load_data  = 8'h5A;
        load_valid = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            load_valid = (k >= 2);
            load_data  = (k == 8) ? 8'hC3 : 8'($urandom_range(0, 255));
            check("h_ready", {31'd0, load_ready}, {31'd0, (k == 8)});
            tick();
        end
        load_valid = 1'b0;
        repeat (9) tick();
        check("h_downstream", {24'd0, dn_reg}, 32'h0000_00C3);

        // mid-word reset: 0xFF interrupted on its 4th bit
        load_data  = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        check("m_valid_pre", {31'd0, serial_valid}, 32'd1);
        #2;
        clear = 1'b0;
        #1;
        check("m_valid", {31'd0, serial_valid}, 32'd0);
        check("m_out",   {31'd0, serial_out},   32'd0);
        check("m_busy",  {31'd0, busy},         32'd0);
        check("m_frame", {31'd0, frame_start},  32'd0);
        check("m_ready", {31'd0, load_ready},   32'd0);
        exp_q.delete();
        tick();
        clear = 1'b1;
        tick();
        check("m_rel_ready", {31'd0, load_ready},   32'd1);
        check("m_rel_valid", {31'd0, serial_valid}, 32'd0);
        load_data  = 8'h01;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (9) tick();
        check("m_downstream", {24'd0, dn_reg}, 32'h0000_0001);

        // MSB-first, WIDTH=4: 1000 then 0110 back-to-back
        load_data2  = 4'b1000;
        load_valid2 = 1'b1;
        check("w4_ready0", {31'd0, load_ready2}, 32'd1);
        tick();
        load_data2 = 4'b0110;
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) load_valid2 = 1'b0;
            check("w4_ready", {31'd0, load_ready2},   {31'd0, (k == 4) || (k >= 8)});
            check("w4_valid", {31'd0, serial_valid2}, {31'd0, (k <= 8)});
            tick();
        end

        // random words with random idle gaps
        for (int w = 0; w < 8; w++) begin
            send_word(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (12) tick();

        check("q8_empty", exp_q.size(),  32'd0);
        check("q4_empty", exp2_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
